// File: rtl/input_pkg.sv
// Shared definitions for the player input controller: switch bit positions,
// move/fire state encodings and the decoded direction type.
package input_pkg;

  localparam int SW_W     = 10;
  localparam int SW_RIGHT = 0;
  localparam int SW_LEFT  = 1;
  localparam int SW_FIRE  = 2;
  localparam int SW_PAUSE = 9;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_DELAY  = 2'd1,
    M_REPEAT = 2'd2
  } move_st_e;

  typedef enum logic {
    F_READY    = 1'b0,
    F_COOLDOWN = 1'b1
  } fire_st_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  // Both switches pressed together cancel out to no direction.
  function automatic dir_e decode_dir(input logic right, input logic left);
    dir_e d;
    case ({left, right})
      2'b01:   d = DIR_RIGHT;
      2'b10:   d = DIR_LEFT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Interval counter advanced by frame ticks. Clear has priority over enable so
// a tick landing on the clearing clock is not counted. tc_o flags that the
// count currently equals the terminal value supplied by the owning FSM.
module tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step on enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/player_input_ctrl.sv
// Player input controller: turns debounced switches into single-clock move,
// fire and pause-toggle events. Intervals are measured in frame ticks.
// Optional feature macro: INPUT_AUTO_REPEAT_EN (hold-to-repeat on moves).
// Without it a held direction produces only the entry / reversal pulse.
module player_input_ctrl
  import input_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 5,
  parameter int FIRE_COOLDOWN = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [SW_W-1:0] SW_db,
  output logic            move_right,
  output logic            move_left,
  output logic            fire,
  output logic            fire_ready,
  output logic            paused
);

  logic [SW_W-1:0] sw_q;
  logic [SW_W-1:0] rise;
  dir_e            dir, dir_q;
  move_st_e        mst_q, mst_d;
  fire_st_e        fst_q, fst_d;
  logic            paused_q, paused_d;
  logic            mr_q, mr_d, ml_q, ml_d, fire_q, fire_d;
  logic            pause_edge, hold_off, cnt_en;
  logic            m_clr, f_clr, f_tc;
  logic [CNT_W-1:0] f_cnt;

  assign rise       = SW_db & ~sw_q;
  assign dir        = decode_dir(SW_db[SW_RIGHT], SW_db[SW_LEFT]);
  assign pause_edge = rise[SW_PAUSE];
  // Events are suppressed while paused and on the clock of either pause edge.
  assign hold_off   = paused_q | pause_edge;
  // Counters freeze while paused.
  assign cnt_en     = tick & ~paused_q;
  assign paused_d   = paused_q ^ pause_edge;

`ifdef INPUT_AUTO_REPEAT_EN
  logic             m_tc;
  logic [CNT_W-1:0] m_cnt, m_term;

  // Delay before the first repeat, then the repeat period.
  assign m_term = (mst_q == M_DELAY) ? CNT_W'(REPEAT_DELAY - 1)
                                     : CNT_W'(REPEAT_PERIOD - 1);

  tick_counter #(.CNT_W(CNT_W)) u_move_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (m_clr),
    .en_i   (cnt_en),
    .term_i (m_term),
    .cnt_o  (m_cnt),
    .tc_o   (m_tc)
  );
`endif

  tick_counter #(.CNT_W(CNT_W)) u_fire_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (f_clr),
    .en_i   (cnt_en),
    .term_i (CNT_W'(FIRE_COOLDOWN - 1)),
    .cnt_o  (f_cnt),
    .tc_o   (f_tc)
  );

  // Move FSM next state and pulses. dir_q lets a non-idle state spot a
  // reversal: while holding, dir can only differ from dir_q by flipping.
  always_comb begin
    mst_d = mst_q;
    mr_d  = 1'b0;
    ml_d  = 1'b0;
    m_clr = 1'b0;
    if (hold_off || dir == DIR_NONE) begin
      mst_d = M_IDLE;
      m_clr = 1'b1;
    end else if (mst_q == M_IDLE || dir != dir_q) begin
      mst_d = M_DELAY;
      m_clr = 1'b1;
      mr_d  = (dir == DIR_RIGHT);
      ml_d  = (dir == DIR_LEFT);
    end
`ifdef INPUT_AUTO_REPEAT_EN
    else if (cnt_en && m_tc) begin
      mst_d = M_REPEAT;
      m_clr = 1'b1;
      mr_d  = (dir == DIR_RIGHT);
      ml_d  = (dir == DIR_LEFT);
    end
`endif
  end

  // Fire FSM next state. Edges seen during cooldown are simply dropped.
  always_comb begin
    fst_d  = fst_q;
    fire_d = 1'b0;
    f_clr  = 1'b0;
    case (fst_q)
      F_READY: begin
        f_clr = 1'b1;
        if (!hold_off && rise[SW_FIRE]) begin
          fire_d = 1'b1;
          fst_d  = F_COOLDOWN;
        end
      end
      F_COOLDOWN: begin
        if (cnt_en && f_tc) begin
          fst_d = F_READY;
          f_clr = 1'b1;
        end
      end
      default: begin
        fst_d = F_READY;
        f_clr = 1'b1;
      end
    endcase
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_q     <= '0;
      dir_q    <= DIR_NONE;
      mst_q    <= M_IDLE;
      fst_q    <= F_READY;
      paused_q <= 1'b0;
      mr_q     <= 1'b0;
      ml_q     <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      sw_q     <= SW_db;
      dir_q    <= dir;
      mst_q    <= mst_d;
      fst_q    <= fst_d;
      paused_q <= paused_d;
      mr_q     <= mr_d;
      ml_q     <= ml_d;
      fire_q   <= fire_d;
    end
  end

  assign move_right = mr_q;
  assign move_left  = ml_q;
  assign fire       = fire_q;
  assign fire_ready = (fst_q == F_READY);
  assign paused     = paused_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl. Expected pulses (kind + clock index)
// are queued when stimulus is driven; a negedge monitor pops and compares
// each pulse the DUT emits. Ticks fire on clock edges whose index is a
// multiple of 4. Set INPUT_AUTO_REPEAT_EN to match the DUT build.
module tb_player_input_ctrl;

  localparam int K_R = 0, K_L = 1, K_F = 2;

  typedef struct { int kind; int cyc; } ev_t;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic [9:0] sw = '0;
  logic       move_right, move_left, fire, fire_ready, paused;

  ev_t sb[$];
  int  cyc = 0, tests = 0, failed = 0;

  player_input_ctrl #(
    .CNT_W(8), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .FIRE_COOLDOWN(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .SW_db(sw),
    .move_right(move_right), .move_left(move_left), .fire(fire),
    .fire_ready(fire_ready), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k-th tick edge strictly after edge n.
  function automatic int nth(input int n, input int k);
    return (n / 4 + 1) * 4 + (k - 1) * 4;
  endfunction

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    tick = ((cyc + 1) % 4 == 0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  // Pulse monitor: every emitted pulse must match the head of the queue.
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t e;
    p = {fire, move_left, move_right};
    check("lr_exclusive", int'(move_right & move_left), 0);
    for (int k = 0; k < 3; k++) begin
      if (p[k]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_pulse_kind%0d_cyc", k), cyc, -1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", k, e.kind);
          check("pulse_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int n, f, t1, p, u, l, v, q;

    // Reset state
    step(); step();
    check("rst_move_right", int'(move_right), 0);
    check("rst_move_left", int'(move_left), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_fire_ready", int'(fire_ready), 1);
    check("rst_paused", int'(paused), 0);
    rst = 1'b1;
    step(); step();

    // Move with hold: entry pulse, then repeats when enabled
    align();
    sw[0] = 1'b1;
    n = cyc + 1;
    push(K_R, n);
`ifdef INPUT_AUTO_REPEAT_EN
    for (int k = 4; nth(n, k) < n + 40; k += 2) push(K_R, nth(n, k));
`endif
    run_to(n + 39);
    sw[0] = 1'b0;
    run_to(n + 60);
    check("sb_empty_move", sb.size(), 0);

    // Fire and cooldown
    align();
    check("fire_ready_idle", int'(fire_ready), 1);
    sw[2] = 1'b1;
    f = cyc + 1;
    push(K_F, f);
    step();
    check("fire_ready_after_shot", int'(fire_ready), 0);
    sw[2] = 1'b0;
    t1 = nth(f, 1);
    run_to(t1 - 1);
    sw[2] = 1'b1;                    // edge at tick 1: must be dropped
    run_to(nth(f, 3) - 1);
    check("fire_ready_before_3", int'(fire_ready), 0);
    step();
    check("fire_ready_after_3", int'(fire_ready), 1);
    sw[2] = 1'b0;
    step();
    sw[2] = 1'b1;
    f = cyc + 1;
    push(K_F, f);
    step();
    check("fire_ready_second_shot", int'(fire_ready), 0);
    run_to(nth(f, 3));
    check("fire_ready_second_done", int'(fire_ready), 1);
    sw = '0;
    run_to(cyc + 8);
    check("sb_empty_fire", sb.size(), 0);

    // Both directions, release to left, reversal restarts the delay
    align();
    sw = 10'd3;
    run_to(cyc + 10);
    sw = 10'd2;
    l = cyc + 1;
    push(K_L, l);
`ifdef INPUT_AUTO_REPEAT_EN
    push(K_L, nth(l, 4));
`endif
    v = nth(l, 5);                   // reversal lands on a tick edge
    push(K_R, v);
`ifdef INPUT_AUTO_REPEAT_EN
    push(K_R, nth(v, 4));
`endif
    run_to(v - 1);
    sw = 10'd1;
    run_to(nth(v, 4) + 1);
    sw = '0;
    run_to(cyc + 10);
    check("sb_empty_dirs", sb.size(), 0);

    // Pause freezes cooldown and blocks moves
    align();
    sw[2] = 1'b1;
    f = cyc + 1;
    push(K_F, f);
    step();
    sw[2] = 1'b0;
    t1 = nth(f, 1);
    run_to(t1);
    sw[9] = 1'b1;
    p = cyc + 1;
    step();
    sw[9] = 1'b0;
    check("paused_set", int'(paused), 1);
    check("paused_fire_ready", int'(fire_ready), 0);
    run_to(p + 5);
    sw[0] = 1'b1;                    // direction held while paused
    run_to(p + 40);
    check("paused_frozen_ready", int'(fire_ready), 0);
    check("paused_still", int'(paused), 1);
    sw[9] = 1'b1;
    u = cyc + 1;
    push(K_R, u + 1);
    step();
    sw[9] = 1'b0;
    check("unpaused", int'(paused), 0);
    run_to(u + 2);
    sw[0] = 1'b0;
    run_to(nth(u, 2) - 1);
    check("unpause_ready_pending", int'(fire_ready), 0);
    step();
    check("unpause_ready", int'(fire_ready), 1);
    sw[2] = 1'b1;                    // fire edge in the pause-edge clock
    sw[9] = 1'b1;
    step();
    check("supp_paused", int'(paused), 1);
    check("supp_fire_ready", int'(fire_ready), 1);
    sw = '0;
    step();
    sw[9] = 1'b1;
    step();
    sw[9] = 1'b0;
    step();
    check("supp_unpaused", int'(paused), 0);
    run_to(cyc + 8);
    check("sb_empty_pause", sb.size(), 0);

    // Reset mid-operation
    align();
    sw[1] = 1'b1;
    l = cyc + 1;
    push(K_L, l);
`ifdef INPUT_AUTO_REPEAT_EN
    push(K_L, nth(l, 4));
`endif
    f = nth(l, 4) + 1;
    run_to(f - 1);
    sw[2] = 1'b1;
    push(K_F, f);
    step();
    sw[2] = 1'b0;
    run_to(f + 2);
    check("pre_reset_fire_ready", int'(fire_ready), 0);
    rst = 1'b0;
    #1;
    check("mid_rst_move_right", int'(move_right), 0);
    check("mid_rst_move_left", int'(move_left), 0);
    check("mid_rst_fire", int'(fire), 0);
    check("mid_rst_fire_ready", int'(fire_ready), 1);
    check("mid_rst_paused", int'(paused), 0);
    step(); step(); step();
    rst = 1'b1;
    q = cyc;
    push(K_L, q + 1);
    run_to(q + 2);
    sw[1] = 1'b0;
    run_to(cyc + 12);
    check("sb_empty_reset", sb.size(), 0);
    check("final_fire_ready", int'(fire_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
